// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32 M-extension multiply/divide unit.
//
// Accepts one request at a time through a valid/ready handshake, runs a
// 32-step radix-2 shift-add multiply or restoring divide on operand
// magnitudes, then spends one extra cycle on two's-complement sign fix-up.
// A divide by zero, signed-divide overflow and non-M instructions skip the
// iterations and complete one cycle after acceptance.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   instruction  RV32 instruction (opcode[6:0], funct3[14:12], funct7[31:25])
//   rs1, rs2     operand A (dividend/multiplicand), operand B (divisor/multiplier)
//   in_valid     request present
//   in_ready     unit idle and able to accept
//   out_valid    result holds a completed value
//   out_ready    downstream consumes result
//   result       registered 32-bit result
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] result
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Control registers
  logic [4:0]        r_cnt;
  logic              r_last;
  logic [DATA_W-1:0] r_result;

  // Datapath registers: r_p is the 64-bit product, or {remainder, quotient}
  // for divides; r_b is the multiplicand or divisor magnitude.
  logic [2*DATA_W-1:0] r_p;
  logic [DATA_W-1:0]   r_b;
  logic [2:0]          r_f3;
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_byp;

  // Decode of the incoming request
  logic [2:0]        w_f3;
  logic              w_is_m;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [DATA_W-1:0] w_mag_a;
  logic [DATA_W-1:0] w_mag_b;
  logic              w_byp;
  logic [DATA_W-1:0] w_byp_val;
  logic              w_unused_ok;

  // One iteration step
  logic [DATA_W:0]     w_mul_sum;
  logic [DATA_W+1:0]   w_div_diff;
  logic [2*DATA_W-1:0] w_p_step;

  // Final sign correction; also selects the half of r_p the op returns.
  function automatic logic [DATA_W-1:0] f_sign_fix(
    input logic [2*DATA_W-1:0] p,
    input logic [2:0]          f3,
    input logic                neg_q,
    input logic                neg_r
  );
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   rem;
    prod = neg_q ? (~p + 64'd1) : p;
    quo  = neg_q ? (~p[DATA_W-1:0] + 32'd1) : p[DATA_W-1:0];
    rem  = neg_r ? (~p[2*DATA_W-1:DATA_W] + 32'd1) : p[2*DATA_W-1:DATA_W];
    if (!f3[2]) begin
      f_sign_fix = (f3 == 3'b000) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];
    end else begin
      f_sign_fix = f3[1] ? rem : quo;
    end
  endfunction

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;

  // Register fields 11:7 and 24:15 carry no meaning for this unit.
  assign w_unused_ok = ^{instruction[24:15], instruction[11:7]};

  always_comb begin
    w_f3      = instruction[14:12];
    w_is_m    = (instruction[6:0] == 7'b0110011) && (instruction[31:25] == 7'b0000001);
    // A is signed for MUL/MULH/MULHSU/DIV/REM; B for MUL/MULH/DIV/REM.
    w_a_neg   = rs1[DATA_W-1] && (w_f3[2] ? !w_f3[0] : (w_f3 != 3'b011));
    w_b_neg   = rs2[DATA_W-1] && (w_f3[2] ? !w_f3[0] : !w_f3[1]);
    w_mag_a   = w_a_neg ? (~rs1 + 32'd1) : rs1;
    w_mag_b   = w_b_neg ? (~rs2 + 32'd1) : rs2;
    w_byp     = !w_is_m;
    w_byp_val = '0;
    if (w_is_m && w_f3[2]) begin
      if (rs2 == '0) begin
        w_byp     = 1'b1;
        w_byp_val = w_f3[1] ? rs1 : '1;
      end else if (!w_f3[0] && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF)) begin
        w_byp     = 1'b1;
        w_byp_val = w_f3[1] ? 32'h0 : 32'h8000_0000;
      end
    end
  end

  always_comb begin
    w_mul_sum  = {1'b0, r_p[2*DATA_W-1:DATA_W]} + (r_p[0] ? {1'b0, r_b} : 33'd0);
    // Trial subtraction of the divisor from {remainder, next dividend bit}.
    w_div_diff = {1'b0, r_p[2*DATA_W-1:DATA_W-1]} - {2'b00, r_b};
    if (!r_f3[2]) begin
      w_p_step = {w_mul_sum, r_p[DATA_W-1:1]};
    end else if (w_div_diff[DATA_W+1]) begin
      w_p_step = {r_p[2*DATA_W-2:0], 1'b0};
    end else begin
      w_p_step = {w_div_diff[DATA_W-1:0], r_p[DATA_W-2:0], 1'b1};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_BUSY;
      S_BUSY:  if (r_byp || r_last) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Control path: iteration counter and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_last   <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt  <= '0;
          r_last <= 1'b0;
        end
        S_BUSY: begin
          if (r_byp) begin
            r_result <= r_p[DATA_W-1:0];
          end else if (r_last) begin
            r_result <= f_sign_fix(r_p, r_f3, r_neg_q, r_neg_r);
          end else if (r_cnt == 5'd31) begin
            r_last <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath: operand capture on accept, one shift step per BUSY cycle
  always_ff @(posedge clk) begin
    if (!rst && (r_state == S_IDLE) && in_valid) begin
      r_p     <= {32'd0, (w_byp ? w_byp_val : w_mag_a)};
      r_b     <= w_mag_b;
      r_f3    <= w_f3;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_byp   <= w_byp;
    end else if ((r_state == S_BUSY) && !r_byp && !r_last) begin
      r_p <= w_p_step;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: directed cases followed by randomized
// requests checked against an arithmetic reference model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        in_valid;
  logic        in_ready;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mul_div_unit dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .rs1         (rs1),
    .rs2         (rs2),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .result      (result)
  );

  task automatic chk(input string tag, input string what, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic is_m);
    return {(is_m ? 7'b0000001 : 7'b0000000), 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  // Reference: RISC-V M semantics via 64-bit integer arithmetic.
  function automatic logic [31:0] ref_res(input logic [31:0] ins, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    longint p;
    logic [63:0] pv;
    logic [2:0] f3;
    if (ins[6:0] != 7'b0110011 || ins[31:25] != 7'b0000001) return 32'h0;
    f3 = ins[14:12];
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (f3)
      3'd0: p = sa * sb;
      3'd1: p = sa * sb;
      3'd2: p = sa * ub;
      3'd3: p = ua * ub;
      3'd4: p = (b == 0) ? -64'sd1 : sa / sb;
      3'd5: p = (b == 0) ? -64'sd1 : ua / ub;
      3'd6: p = (b == 0) ? sa : sa % sb;
      default: p = (b == 0) ? ua : ua % ub;
    endcase
    pv = 64'(p);
    if (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3) return pv[63:32];
    return pv[31:0];
  endfunction

  function automatic int ref_lat(input logic [31:0] ins, input logic [31:0] a,
                                 input logic [31:0] b);
    logic [2:0] f3;
    f3 = ins[14:12];
    if (ins[6:0] != 7'b0110011 || ins[31:25] != 7'b0000001) return 1;
    if (f3 >= 3'd4 && b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Called #1 after a rising edge with the unit idle. hold: cycles to keep
  // out_ready low in DONE while in_valid is asserted; pulse: raise in_valid
  // for one cycle while BUSY.
  task automatic run_op(input string tag, input logic [31:0] ins, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int hold, input bit pulse);
    int lat;
    chk(tag, "in_ready_idle", {31'b0, in_ready}, 32'd1);
    instruction = ins;
    rs1 = a;
    rs2 = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    instruction = mk(3'd0, 1'b1);
    rs1 = $urandom;
    rs2 = $urandom;
    chk(tag, "in_ready_busy", {31'b0, in_ready}, 32'd0);
    lat = 0;
    do begin
      in_valid = pulse && (lat == 5);
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 100);
    in_valid = 1'b0;
    chk(tag, "latency", 32'(lat), 32'(exp_lat));
    chk(tag, "result", result, exp);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk(tag, "hold_result", result, exp);
      chk(tag, "hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk(tag, "out_valid_after", {31'b0, out_valid}, 32'd0);
    chk(tag, "in_ready_after", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    instruction = '0;
    rs1 = '0;
    rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", "in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset", "out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset", "result", result, 32'd0);

    // Request while in reset must not be taken
    instruction = mk(3'd0, 1'b1);
    rs1 = 32'd5;
    rs2 = 32'd6;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b0;
    chk("rst_accept", "in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("rst_accept", "in_ready2", {31'b0, in_ready}, 32'd1);

    run_op("mul_7_m3", mk(3'd0, 1'b1), 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0, 0);
    run_op("mulhu_ff", mk(3'd3, 1'b1), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0, 0);
    run_op("mulh_ff", mk(3'd1, 1'b1), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 33, 0, 0);
    run_op("mulhsu_ff", mk(3'd2, 1'b1), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0, 0);
    run_op("div_m7_2", mk(3'd4, 1'b1), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0, 0);
    run_op("rem_m7_2", mk(3'd6, 1'b1), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0, 0);
    run_op("divu_100_7", mk(3'd5, 1'b1), 32'd100, 32'd7, 32'd14, 33, 0, 0);
    run_op("remu_100_7", mk(3'd7, 1'b1), 32'd100, 32'd7, 32'd2, 33, 0, 0);
    run_op("div_5_0", mk(3'd4, 1'b1), 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 0);
    run_op("rem_5_0", mk(3'd6, 1'b1), 32'd5, 32'd0, 32'd5, 1, 0, 0);
    run_op("div_ovf", mk(3'd4, 1'b1), 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 0);
    run_op("rem_ovf", mk(3'd6, 1'b1), 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0, 0);
    run_op("non_m", mk(3'd0, 1'b0), 32'd9, 32'd4, 32'h0, 1, 0, 0);

    // Reset in the middle of an iteration
    instruction = mk(3'd0, 1'b1);
    rs1 = 32'h1234;
    rs2 = 32'h5678;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst", "in_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_rst", "out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst", "result", result, 32'd0);
    run_op("mul_3_4", mk(3'd0, 1'b1), 32'd3, 32'd4, 32'd12, 33, 0, 0);

    // Back-pressure in DONE plus a stray request during BUSY
    run_op("hold", mk(3'd4, 1'b1), 32'd1000, 32'hFFFF_FFF9, 32'hFFFF_FF72, 33, 5, 1);

    for (int n = 0; n < 40; n++) begin
      int sel;
      ins = mk(3'($urandom_range(0, 7)), ($urandom_range(0, 7) != 0));
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 5);
      if (sel == 0) b = 32'h0;
      else if (sel == 1) begin
        a = $urandom_range(0, 300) - 150;
        b = $urandom_range(0, 20) - 10;
      end else if (sel == 2) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      run_op($sformatf("rand%0d", n), ins, a, b, ref_res(ins, a, b), ref_lat(ins, a, b),
             0, ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous active-high reset, rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high; sampled on the rising clk edge.
REQ-004 instruction  input  32  RV32 instruction; decoded fields are opcode[6:0], funct3[14:12] and funct7[31:25].
REQ-005 rs1  input  32  operand A (dividend or multiplicand).
REQ-006 rs2  input  32  operand B (divisor or multiplier).
REQ-007 in_valid  input  1  the upstream side has a request on instruction/rs1/rs2.
REQ-008 in_ready  output  1  the block can accept a request.
REQ-009 out_valid  output  1  result holds a completed value.
REQ-010 out_ready  input  1  the downstream side consumes result.
REQ-011 result  output  32  the completed result.

Function
REQ-012 A request SHALL be accepted on a rising edge where in_valid && in_ready; instruction, rs1 and rs2 are latched internally at that edge and may change afterwards.
REQ-013 The block SHALL implement a three-state FSM: IDLE (in_ready=1, out_valid=0), BUSY (in_ready=0, out_valid=0), DONE (in_ready=0, out_valid=1).
REQ-014 Transitions: IDLE->BUSY on accept; BUSY->DONE when the iteration counter completes; DONE->IDLE on the edge where out_ready=1.
REQ-015 M-extension ops apply only when opcode=0110011 and funct7=0000001, selected by funct3: 000 MUL (low 32), 001 MULH (s*s high 32), 010 MULHSU (s*u high 32), 011 MULHU (u*u high 32), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-016 Multiply SHALL use radix-2 iterative shift-add on operand magnitudes, with a 64-bit product and a final two's-complement sign correction.
REQ-017 Divide SHALL use a restoring, one-bit-per-cycle divider on magnitudes; the quotient sign is sign(A) xor sign(B) and the remainder sign is sign(A), for signed ops only.
REQ-018 A 5-bit iteration counter SHALL run 0..31, one step per edge in BUSY, followed by one sign-correction edge; for an accept at edge N, out_valid is high after edge N+33.
REQ-019 The following special cases SHALL bypass iteration and give out_valid after edge N+1:
- divisor=0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1.
- DIV with rs1=0x80000000 and rs2=0xFFFFFFFF -> 0x80000000.
- REM with the same operands -> 0.
REQ-020 A non-M instruction SHALL be accepted, produce result=0 and take the bypass timing.
REQ-021 result and out_valid SHALL hold stable in DONE until out_ready=1; there is no input acceptance in DONE, and no back-to-back accept on the same edge as output consumption.
REQ-022 in_valid while BUSY or DONE SHALL be ignored; only an accept latches inputs.
REQ-023 result SHALL be registered; no combinational path from inputs to result, out_valid or in_ready.

Reset
REQ-024 When rst=1 at an edge, the FSM SHALL go to IDLE, and in_ready=1, out_valid=0, result=0, counter=0, regardless of the current state. Any in-flight operation is discarded.
REQ-025 While rst=1, no request SHALL be accepted, even if in_valid=1.

Verification
REQ-026 MUL rs1=7, rs2=-3 (0xFFFFFFFD) -> result=0xFFFFFFEB; out_valid first high after edge N+33.
REQ-027 MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000; MULHSU -1*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-028 DIV -7/2 -> 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
REQ-029 DIV 5/0 -> 0xFFFFFFFF and REM 5,0 -> 5, each valid after edge N+1; DIV 0x80000000/-1 -> 0x80000000 and REM -> 0.
REQ-030 Assert rst at BUSY iteration 10 -> the next edge gives IDLE, in_ready=1, out_valid=0, result=0; a new MUL 3*4 then returns 12.
REQ-031 Hold out_ready=0 for 5 cycles in DONE -> result stable and in_ready=0 throughout; out_ready=1 -> IDLE on the next edge; an in_valid pulse during BUSY is not accepted.
